// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC and IF/ID owner applying hazard stall/flush, ID-stage branch redirect, debug counters and stall watchdog
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic             id_ex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o,
  output logic             stall_timeout_o
);
  localparam int RW = $clog2(MAX_STALL + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL);
  logic [RW-1:0] r_run;
  logic [31:0]   w_pc4;
  logic          w_redirect;
  assign w_pc4 = pc_o + 32'd4;
  assign w_redirect = ~stall_i & branch_taken_i & if_id_valid_o;
  assign id_ex_bubble_o = ~rst_n | flush_i | ~if_id_valid_o;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_o            <= RESET_PC;
      if_id_instr_o   <= '0;
      if_id_pc4_o     <= '0;
      if_id_valid_o   <= 1'b0;
      stall_cnt_o     <= '0;
      squash_cnt_o    <= '0;
      r_run           <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      if (w_redirect) begin
        pc_o          <= {branch_target_i[31:2], 2'b00};
        if_id_instr_o <= '0;
        if_id_pc4_o   <= '0;
        if_id_valid_o <= 1'b0;
      end else if (!stall_i) begin
        pc_o          <= w_pc4;
        if_id_instr_o <= instr_i;
        if_id_pc4_o   <= w_pc4;
        if_id_valid_o <= 1'b1;
      end
      if (stall_i && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (w_redirect && !(&squash_cnt_o)) squash_cnt_o <= squash_cnt_o + 1'b1;
      r_run <= !stall_i ? '0 : (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
      if (stall_i && r_run == RUN_MAX) stall_timeout_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: directed vectors with a queue scoreboard checked by an independent monitor
module tb_fetch_stage_ctrl;
  localparam int CNT_W = 3;
  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        bubble;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] sq;
    logic        to;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr_i = '0;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;
  logic branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] pc_o, if_id_instr_o, if_id_pc4_o;
  logic if_id_valid_o, id_ex_bubble_o, stall_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, squash_cnt_o;
  exp_t q[$];
  int applied = 0;
  int miscompares = 0;
  int vid = 0;
  fetch_stage_ctrl #(.RESET_PC(32'h0), .CNT_W(CNT_W), .MAX_STALL(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i), .pc_o(pc_o),
    .if_id_instr_o(if_id_instr_o), .if_id_pc4_o(if_id_pc4_o), .if_id_valid_o(if_id_valid_o),
    .id_ex_bubble_o(id_ex_bubble_o), .stall_cnt_o(stall_cnt_o), .squash_cnt_o(squash_cnt_o),
    .stall_timeout_o(stall_timeout_o)
  );
  always #5 clk = ~clk;
  task automatic vec(input logic rn, input logic st, input logic fl, input logic bt,
                     input logic [31:0] tgt, input logic [31:0] ins,
                     input logic [31:0] e_pc, input logic [31:0] e_ins, input logic [31:0] e_pc4,
                     input logic e_v, input logic e_b, input int e_sc, input int e_sq, input logic e_to);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = rn; stall_i = st; flush_i = fl; branch_taken_i = bt; branch_target_i = tgt; instr_i = ins;
    vid++;
    e.id = vid; e.pc = e_pc; e.instr = e_ins; e.pc4 = e_pc4; e.valid = e_v; e.bubble = e_b;
    e.sc = CNT_W'(e_sc); e.sq = CNT_W'(e_sq); e.to = e_to;
    q.push_back(e);
  endtask
  task automatic chk(input string n, input int id, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL v%0d %s: got %h expected %h", id, n, act, req);
    end
  endtask
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        applied++;
        chk("pc", e.id, pc_o, e.pc);
        chk("if_id_instr", e.id, if_id_instr_o, e.instr);
        if (e.valid) chk("if_id_pc4", e.id, if_id_pc4_o, e.pc4);
        chk("if_id_valid", e.id, {31'b0, if_id_valid_o}, {31'b0, e.valid});
        chk("bubble", e.id, {31'b0, id_ex_bubble_o}, {31'b0, e.bubble});
        chk("stall_cnt", e.id, 32'(stall_cnt_o), 32'(e.sc));
        chk("squash_cnt", e.id, 32'(squash_cnt_o), 32'(e.sq));
        chk("timeout", e.id, {31'b0, stall_timeout_o}, {31'b0, e.to});
      end
    end
  end
  initial begin
    //  rn st fl bt target        instr          pc            ifid          pc4           v  b  sc sq to
    vec(0, 0, 0, 0, 32'h0,        32'h0,         32'h0,        32'h0,        32'h0,        0, 1, 0, 0, 0);
    vec(0, 0, 0, 0, 32'h0,        32'h0,         32'h0,        32'h0,        32'h0,        0, 1, 0, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        32'h1111_1111, 32'h4,        32'h1111_1111, 32'h4,       1, 0, 0, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        32'h2222_2222, 32'h8,        32'h2222_2222, 32'h8,       1, 0, 0, 0, 0);
    vec(1, 1, 1, 0, 32'h0,        32'h3333_3333, 32'h8,        32'h2222_2222, 32'h8,       1, 1, 1, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        32'h3333_3333, 32'hC,        32'h3333_3333, 32'hC,       1, 0, 1, 0, 0);
    vec(1, 0, 0, 1, 32'h102,      32'h4444_4444, 32'h100,      32'h0,        32'h0,        0, 1, 1, 1, 0);
    vec(1, 0, 0, 1, 32'h200,      32'h5555_5555, 32'h104,      32'h5555_5555, 32'h104,     1, 0, 1, 1, 0);
    vec(1, 1, 0, 1, 32'h200,      32'hDEAD_BEEF, 32'h104,      32'h5555_5555, 32'h104,     1, 0, 2, 1, 0);
    vec(1, 0, 0, 1, 32'h200,      32'hDEAD_BEEF, 32'h200,      32'h0,        32'h0,        0, 1, 2, 2, 0);
    vec(1, 1, 0, 0, 32'h0,        32'hDEAD_BEEF, 32'h200,      32'h0,        32'h0,        0, 1, 3, 2, 0);
    vec(1, 1, 0, 0, 32'h0,        32'hDEAD_BEEF, 32'h200,      32'h0,        32'h0,        0, 1, 4, 2, 0);
    vec(1, 1, 0, 0, 32'h0,        32'hDEAD_BEEF, 32'h200,      32'h0,        32'h0,        0, 1, 5, 2, 0);
    vec(1, 1, 0, 0, 32'h0,        32'hDEAD_BEEF, 32'h200,      32'h0,        32'h0,        0, 1, 6, 2, 0);
    vec(1, 1, 0, 0, 32'h0,        32'hDEAD_BEEF, 32'h200,      32'h0,        32'h0,        0, 1, 7, 2, 1);
    vec(1, 0, 0, 0, 32'h0,        32'h6666_6666, 32'h204,      32'h6666_6666, 32'h204,     1, 0, 7, 2, 1);
    vec(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 1, 7, 3, 1);
    vec(1, 0, 0, 0, 32'h0,        32'h7777_7777, 32'h0,        32'h7777_7777, 32'h0,       1, 0, 7, 3, 1);
    vec(1, 1, 0, 0, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'h7777_7777, 32'h0,       1, 0, 7, 3, 1);
    vec(0, 1, 0, 1, 32'h300,      32'hDEAD_BEEF, 32'h0,        32'h0,        32'h0,        0, 1, 0, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        32'h8888_8888, 32'h4,        32'h8888_8888, 32'h4,       1, 0, 0, 0, 0);
    vec(1, 0, 1, 0, 32'h0,        32'h9999_9999, 32'h8,        32'h9999_9999, 32'h8,       1, 1, 0, 0, 0);
    vec(1, 0, 0, 0, 32'h0,        32'hAAAA_AAAA, 32'hC,        32'hAAAA_AAAA, 32'hC,       1, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
